data_memory_hs: RTL and testbench
=================================

// Module: data_memory_hs
// PURPOSE
//  Handshaked, parametrised data memory for the RV32 load/store path. Accepts one
//  request at a time (valid/ready), runs byte/half/word loads and stores on a
//  synchronous-read word RAM, and returns a registered response (valid/ready).
//  Out-of-range and misaligned accesses are detected; misaligned ones can optionally
//  be split into two word beats. Sits between the MEM stage and the data RAM.
// PARAMETERS
//  DEPTH_WORDS  256  RAM depth in 32-bit words; word index = req_addr[31:2]
//  AW           8    word-index width, must be >= clog2(DEPTH_WORDS)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  req_valid    in   1   request valid
//  req_ready    out  1   request ready; high only in IDLE
//  req_we       in   1   1 = store, 0 = load
//  req_addr     in   32  byte address
//  req_rw_type  in   3   [1:0] 00 byte, 01 half, 10 word, 11 reserved; [2] 1 = unsigned load
//  req_wdata    in   32  store data, LSB-aligned
//  rsp_valid    out  1   response valid
//  rsp_ready    in   1   response consumed
//  rsp_rdata    out  32  load data, sign/zero extended; 0 for stores and errors
//  rsp_err      out  1   1 = access rejected, memory untouched
// BEHAVIOUR
//  - Reset: FSM->IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM not cleared.
//  - FSM IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE. Request captured on req_valid&req_ready.
//  - IDLE: req_ready=1. On accept, decode; error -> RESP directly, else -> ACC0.
//  - ACC0: RAM op on word w0 = addr[31:2]; split -> ACC1, else -> RESP.
//  - ACC1: RAM op on word w0+1; -> RESP.
//  - RESP: rsp_valid=1, rsp_* held stable until rsp_ready; then IDLE. No accept in
//    the RESP->IDLE transition cycle (req_ready low throughout RESP).
//  - Latency, accept in cycle n: error rsp_valid in n+1; aligned in n+2; split in n+3.
//  - Errors: rw_type[1:0]=11; any touched word index >= DEPTH_WORDS (checked for both
//    words before any write); misaligned (half with addr[0]=1, word with addr[1:0]!=0)
//    when split disabled. Error -> rsp_err=1, rsp_rdata=0, no RAM write.
//  - Stores: read-modify-write via byte-enable mask; byte lane = addr[1:0], half lane =
//    addr[1]; untouched bytes preserved. Split store: mask spans 8 bytes {w1,w0}.
//  - Loads: selected byte/half from {w1,w0} >> (8*addr[1:0]); ext per rw_type[2];
//    word loads ignore rw_type[2].
//  - Reset mid-operation: FSM->IDLE, response dropped; a write performed at ACC0 edge
//    stays committed (split store may be half-written; caller must re-issue).
//  - Request fields ignored outside IDLE; req_valid while busy has no effect.
// CONFIGURATION
//  - MISALIGN_SPLIT_EN defined: misaligned half/word accesses execute as two beats
//    (ACC0, ACC1); aligned accesses and bytes never split.
//  - MISALIGN_SPLIT_EN undefined: ACC1 unreachable; misaligned -> rsp_err=1 in n+1.
// TESTING
//  1. sw 0x11223344 @0x10, then lw @0x10 -> rdata 0x11223344, err 0, rsp_valid at n+2.
//  2. sb 0xAA @0x13; lb @0x13 -> 0xFFFFFFAA; lbu @0x13 -> 0x000000AA; lw @0x10 -> 0xAA223344.
//  3. sh 0x8001 @0x12; lh @0x12 -> 0xFFFF8001; lhu -> 0x00008001; lw @0x10 -> 0x80013344.
//  4. Without macro: lh @0x11 -> err 1, rdata 0, n+1; sw @0x11 leaves 0x10/0x14 unchanged.
//     With macro: sw 0x11223344 @0x10, sw 0x55667788 @0x14; lw @0x12 -> 0x77881122 at n+3;
//     lh @0x13 -> 0xFFFF8811; sw 0xDEADBEEF @0x12 -> @0x10=0xBEEF3344, @0x14=0x5566DEAD.
//  5. DEPTH_WORDS=256: lw @0x400 -> err; (macro) sw @0x3FE -> err, word 255 unchanged;
//     rw_type=3'b011 -> err.
//  6. Hold rsp_ready=0 5 cycles with req_valid=1: rsp_* stable, req_ready=0, no second
//     accept; rst_n pulsed low in ACC0 -> rsp_valid=0, req_ready=1 next cycle after release.

Source files
------------

// File: rtl/data_memory_hs.sv
// Handshaked RV32 data memory: byte/half/word loads and stores on a synchronous-read word RAM.
// Optional macro MISALIGN_SPLIT_EN executes misaligned half/word accesses as two word beats.
module data_memory_hs #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_rw_type,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_rd_data;
  logic [1:0]    r_state;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_uns;
  logic          r_we;
  logic          r_split;
  logic [7:0]    r_mask;
  logic [63:0]   r_wdata;
  logic [31:0]   r_lo;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_accept;
  logic [1:0]    w_size;
  logic          w_misalign;
  logic          w_split;
  logic          w_align_err;
  logic [31:0]   w_word0;
  logic          w_oor;
  logic          w_err;
  logic [7:0]    w_mask_base;
  logic [7:0]    w_mask;
  logic [63:0]   w_wdata;
  logic [AW-1:0] w_rd_idx;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_idx;
  logic [3:0]    w_wr_mask;
  logic [31:0]   w_wr_src;
  logic [31:0]   w_wr_data;
  logic [31:0]   w_lo;
  logic [31:0]   w_hi;
  logic [63:0]   w_shifted;
  logic [31:0]   w_load;

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_accept   = req_valid & req_ready;
  assign w_size     = req_rw_type[1:0];
  assign w_misalign = ((w_size == 2'b01) & req_addr[0]) | ((w_size == 2'b10) & (|req_addr[1:0]));
`ifdef MISALIGN_SPLIT_EN
  assign w_split     = w_misalign;
  assign w_align_err = 1'b0;
`else
  assign w_split     = 1'b0;
  assign w_align_err = w_misalign;
`endif

  // Both touched words are range-checked up front so a split store never half-commits on error.
  assign w_word0 = {2'b00, req_addr[31:2]};
  assign w_oor   = (w_word0 >= 32'(DEPTH_WORDS)) |
                   (w_split & ((w_word0 + 32'd1) >= 32'(DEPTH_WORDS)));
  assign w_err   = (w_size == 2'b11) | w_align_err | w_oor;

  always_comb begin
    w_mask_base = 8'h0F;
    case (w_size)
      2'b00:   w_mask_base = 8'h01;
      2'b01:   w_mask_base = 8'h03;
      default: w_mask_base = 8'h0F;
    endcase
  end
  assign w_mask  = w_mask_base << req_addr[1:0];
  assign w_wdata = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};

  // Read is launched at the accept edge so word 0 is available during ACC0 for the merge.
  assign w_rd_idx  = (r_state == S_IDLE) ? req_addr[AW+1:2] : r_idx + AW'(1);
  assign w_wr_en   = r_we & ((r_state == S_ACC0) | (r_state == S_ACC1));
  assign w_wr_idx  = (r_state == S_ACC1) ? r_idx + AW'(1) : r_idx;
  assign w_wr_mask = (r_state == S_ACC1) ? r_mask[7:4] : r_mask[3:0];
  assign w_wr_src  = (r_state == S_ACC1) ? r_wdata[63:32] : r_wdata[31:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign w_wr_data[8*gi +: 8] = w_wr_mask[gi] ? w_wr_src[8*gi +: 8] : r_rd_data[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
    r_rd_data <= r_mem[w_rd_idx];
  end

  assign w_lo      = (r_state == S_ACC1) ? r_lo : r_rd_data;
  assign w_hi      = (r_state == S_ACC1) ? r_rd_data : 32'h0;
  assign w_shifted = {w_hi, w_lo} >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shifted[31:0];
    case (r_size)
      2'b00:   w_load = r_uns ? {24'h0, w_shifted[7:0]} : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = r_uns ? {16'h0, w_shifted[15:0]} : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_off   <= 2'b00;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_we    <= 1'b0;
      r_split <= 1'b0;
      r_mask  <= 8'h00;
      r_wdata <= 64'h0;
      r_lo    <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx   <= req_addr[AW+1:2];
            r_off   <= req_addr[1:0];
            r_size  <= w_size;
            r_uns   <= req_rw_type[2];
            r_we    <= req_we & ~w_err;
            r_split <= w_split;
            r_mask  <= w_mask;
            r_wdata <= w_wdata;
            r_rdata <= 32'h0;
            r_err   <= w_err;
            r_state <= w_err ? S_RESP : S_ACC0;
          end
        end
        S_ACC0: begin
          if (r_split) begin
            r_lo    <= r_rd_data;
            r_state <= S_ACC1;
          end else begin
            r_rdata <= r_we ? 32'h0 : w_load;
            r_state <= S_RESP;
          end
        end
        S_ACC1: begin
          r_rdata <= r_we ? 32'h0 : w_load;
          r_state <= S_RESP;
        end
        default: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed self-checking bench for data_memory_hs (default build; MISALIGN_SPLIT_EN adds split checks).
module tb_data_memory_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_rw_type = 3'b010;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_memory_hs #(.DEPTH_WORDS(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_rw_type(req_rw_type), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // One request/response; entered and left #1 after a rising edge with the DUT idle.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] t,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_rw_type = t; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) lat = 99;
    rd = rsp_rdata; er = rsp_err;
    $display("xact we=%0d addr=%h type=%b wd=%h -> rdata=%h err=%0d lat=%0d", we, addr, t, wd, rd, er, lat);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset: got rdy=%b vld=%b err=%b rd=%h, want 1 0 0 00000000", req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h10, 3'b010, 32'h11223344, rd, er, lat);
    n_cmp++;
    if ({er, rd, lat} !== {1'b0, 32'h0, 32'd2}) begin
      n_bad++; $display("FAIL sw_0x10: got err=%b rd=%h lat=%0d, want 0 00000000 2", er, rd, lat);
    end
    xact(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd, lat} !== {1'b0, 32'h11223344, 32'd2}) begin
      n_bad++; $display("FAIL lw_0x10: got err=%b rd=%h lat=%0d, want 0 11223344 2", er, rd, lat);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h13, 3'b000, 32'h000000AA, rd, er, lat);
    xact(1'b0, 32'h13, 3'b000, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'hFFFFFFAA}) begin
      n_bad++; $display("FAIL lb_0x13: got err=%b rd=%h, want 0 ffffffaa", er, rd);
    end
    xact(1'b0, 32'h13, 3'b100, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'h000000AA}) begin
      n_bad++; $display("FAIL lbu_0x13: got err=%b rd=%h, want 0 000000aa", er, rd);
    end
    xact(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'hAA223344}) begin
      n_bad++; $display("FAIL lw_after_sb: got err=%b rd=%h, want 0 aa223344", er, rd);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h12, 3'b001, 32'h00008001, rd, er, lat);
    xact(1'b0, 32'h12, 3'b001, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'hFFFF8001}) begin
      n_bad++; $display("FAIL lh_0x12: got err=%b rd=%h, want 0 ffff8001", er, rd);
    end
    xact(1'b0, 32'h12, 3'b101, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'h00008001}) begin
      n_bad++; $display("FAIL lhu_0x12: got err=%b rd=%h, want 0 00008001", er, rd);
    end
    xact(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'h80013344}) begin
      n_bad++; $display("FAIL lw_after_sh: got err=%b rd=%h, want 0 80013344", er, rd);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
`ifdef MISALIGN_SPLIT_EN
    xact(1'b1, 32'h10, 3'b010, 32'h11223344, rd, er, lat);
    xact(1'b1, 32'h14, 3'b010, 32'h55667788, rd, er, lat);
    xact(1'b0, 32'h12, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd, lat} !== {1'b0, 32'h77881122, 32'd3}) begin
      n_bad++; $display("FAIL split_lw_0x12: got err=%b rd=%h lat=%0d, want 0 77881122 3", er, rd, lat);
    end
    xact(1'b0, 32'h13, 3'b001, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'hFFFF8811}) begin
      n_bad++; $display("FAIL split_lh_0x13: got err=%b rd=%h, want 0 ffff8811", er, rd);
    end
    xact(1'b1, 32'h12, 3'b010, 32'hDEADBEEF, rd, er, lat);
    xact(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'hBEEF3344}) begin
      n_bad++; $display("FAIL split_sw_lo: got err=%b rd=%h, want 0 beef3344", er, rd);
    end
    xact(1'b0, 32'h14, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'h5566DEAD}) begin
      n_bad++; $display("FAIL split_sw_hi: got err=%b rd=%h, want 0 5566dead", er, rd);
    end
`else
    xact(1'b1, 32'h14, 3'b010, 32'hCAFEF00D, rd, er, lat);
    xact(1'b0, 32'h11, 3'b001, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd, lat} !== {1'b1, 32'h0, 32'd1}) begin
      n_bad++; $display("FAIL misaligned_lh: got err=%b rd=%h lat=%0d, want 1 00000000 1", er, rd, lat);
    end
    xact(1'b1, 32'h11, 3'b010, 32'h99999999, rd, er, lat);
    n_cmp++;
    if ({er, rd, lat} !== {1'b1, 32'h0, 32'd1}) begin
      n_bad++; $display("FAIL misaligned_sw: got err=%b rd=%h lat=%0d, want 1 00000000 1", er, rd, lat);
    end
    xact(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'h80013344}) begin
      n_bad++; $display("FAIL word_0x10_kept: got err=%b rd=%h, want 0 80013344", er, rd);
    end
    xact(1'b0, 32'h14, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'hCAFEF00D}) begin
      n_bad++; $display("FAIL word_0x14_kept: got err=%b rd=%h, want 0 cafef00d", er, rd);
    end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h3FC, 3'b010, 32'h0BADCAFE, rd, er, lat);
    xact(1'b0, 32'h400, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd, lat} !== {1'b1, 32'h0, 32'd1}) begin
      n_bad++; $display("FAIL lw_out_of_range: got err=%b rd=%h lat=%0d, want 1 00000000 1", er, rd, lat);
    end
    xact(1'b1, 32'h3FE, 3'b010, 32'h12345678, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL sw_0x3fe: got err=%b rd=%h, want 1 00000000", er, rd);
    end
    xact(1'b1, 32'h3FC, 3'b011, 32'h12345678, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL reserved_type: got err=%b rd=%h, want 1 00000000", er, rd);
    end
    xact(1'b0, 32'h3FC, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'h0BADCAFE}) begin
      n_bad++; $display("FAIL word_255_kept: got err=%b rd=%h, want 0 0badcafe", er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_rd;
    int lat;
`ifdef MISALIGN_SPLIT_EN
    exp_rd = 32'hBEEF3344;
`else
    exp_rd = 32'h80013344;
`endif
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_rw_type = 3'b010;
    @(posedge clk); #1;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("xact held lw addr=00000010 -> rdata=%h err=%0d lat=%0d", rsp_rdata, rsp_err, lat);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, exp_rd}) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b err=%b rd=%h, want 1 0 0 %h", i, rsp_valid, req_ready, rsp_err, rsp_rdata, exp_rd);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
        n_bad++; $display("FAIL no_second_accept%0d: got vld=%b rdy=%b, want 0 1", i, rsp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_rw_type = 3'b010; req_wdata = 32'h55555555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_bad++; $display("FAIL reset_in_acc0: got vld=%b rdy=%b, want 0 1", rsp_valid, req_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_bad++; $display("FAIL after_release: got vld=%b rdy=%b, want 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL response_dropped: got vld=%b, want 0", rsp_valid);
    end
    xact(1'b0, 32'h3FC, 3'b010, 32'h0, rd, er, lat);
    n_cmp++;
    if ({er, rd, lat} !== {1'b0, 32'h0BADCAFE, 32'd2}) begin
      n_bad++; $display("FAIL lw_after_reset: got err=%b rd=%h lat=%0d, want 0 0badcafe 2", er, rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
